// File: rtl/wishbone_board_mem_pkg.sv
// Shared bus widths and arbiter state encoding for the board-state RAM.
package wishbone_board_mem_pkg;
  localparam int WB_ADDR_W = 8;
  localparam int WB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_R = 2'd1,
    OWN_W = 2'd2
  } arb_state_t;
endpackage

// File: rtl/wishbone_board_mem_if.sv
// Wishbone pipelined-mode signal bundle; names are from the master's point of view.
interface wishbone_if
  import wishbone_board_mem_pkg::*;
#(
  parameter int AW = WB_ADDR_W,
  parameter int DW = WB_DATA_W
);
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic          stall_i;
  logic          ack_i;
  logic [DW-1:0] dat_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  stall_i, ack_i, dat_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output stall_i, ack_i, dat_i
  );
endinterface

// File: rtl/wishbone_board_mem_arb.sv
// Two-way cycle arbiter: the owner keeps the memory for its whole cyc_o; R wins ties.
module wb_arbiter2
  import wishbone_board_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_r,
  input  logic req_w,
  output logic grant_r,
  output logic grant_w
);
  arb_state_t r_state;
  arb_state_t w_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Release hands straight over to a waiting requester, no idle cycle in between
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_r)      w_next = OWN_R;
        else if (req_w) w_next = OWN_W;
      end
      OWN_R: if (!req_r) w_next = req_w ? OWN_W : IDLE;
      OWN_W: if (!req_w) w_next = req_r ? OWN_R : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign grant_r = (r_state == OWN_R);
  assign grant_w = (r_state == OWN_W);
endmodule

// File: rtl/wishbone_board_mem.sv
// 256 x 8 board-state RAM shared by a write-capable master (W) and a read-only master (R).
module wishbone_board_mem
  import wishbone_board_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int DEPTH      = 2**ADDR_WIDTH
)(
  input  logic       clk,
  input  logic       rst,
  wishbone_if.slave  master_w,
  wishbone_if.slave  master_r
);
  logic                  grant_r;
  logic                  grant_w;
  logic                  w_acc_w;
  logic                  w_acc_r;
  logic                  r_ack_w;
  logic                  r_ack_r;
  logic [DATA_WIDTH-1:0] r_dat_w;
  logic [DATA_WIDTH-1:0] r_dat_r;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  wb_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_r   (master_r.cyc_o),
    .req_w   (master_w.cyc_o),
    .grant_r (grant_r),
    .grant_w (grant_w)
  );

  assign w_acc_w = master_w.cyc_o & master_w.stb_o & grant_w;
  assign w_acc_r = master_r.cyc_o & master_r.stb_o & grant_r;

  // Contents survive reset; only W can write, R's we_o is ignored
  always_ff @(posedge clk) begin
    if (w_acc_w && master_w.we_o) r_mem[master_w.adr_o] <= master_w.dat_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_w <= 1'b0;
      r_ack_r <= 1'b0;
      r_dat_w <= '0;
      r_dat_r <= '0;
    end else begin
      r_ack_w <= w_acc_w;
      r_ack_r <= w_acc_r;
      if (w_acc_w) r_dat_w <= r_mem[master_w.adr_o];
      if (w_acc_r) r_dat_r <= r_mem[master_r.adr_o];
    end
  end

  // An ack still in flight when the owner drops cyc_o is swallowed here
  assign master_w.stall_i = master_w.cyc_o & ~grant_w;
  assign master_w.ack_i   = r_ack_w & master_w.cyc_o;
  assign master_w.dat_i   = r_dat_w;

  assign master_r.stall_i = master_r.cyc_o & ~grant_r;
  assign master_r.ack_i   = r_ack_r & master_r.cyc_o;
  assign master_r.dat_i   = r_dat_r;
endmodule

// File: tb/tb_wishbone_board_mem.sv
// Scoreboard bench for the shared board RAM: transfers push expectations, acks pop them.
module tb_wishbone_board_mem;
  import wishbone_board_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wishbone_if mw ();
  wishbone_if mr ();

  wishbone_board_mem dut (
    .clk      (clk),
    .rst      (rst_n),
    .master_w (mw),
    .master_r (mr)
  );

  typedef struct packed {
    logic       chk;
    logic [7:0] data;
  } exp_t;

  exp_t       q_w[$];
  exp_t       q_r[$];
  exp_t       mon_e;
  logic [7:0] model [256];
  logic       model_vld [256];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit is_w, input logic cyc, input logic stb, input logic we,
                       input logic [7:0] adr, input logic [7:0] dat);
    if (is_w) begin
      mw.cyc_o = cyc; mw.stb_o = stb; mw.we_o = we; mw.adr_o = adr; mw.dat_o = dat;
    end else begin
      mr.cyc_o = cyc; mr.stb_o = stb; mr.we_o = we; mr.adr_o = adr; mr.dat_o = dat;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds stb until the port is unstalled, records the expectation, then drops stb
  task automatic issue(input bit is_w, input logic we, input logic [7:0] adr, input logic [7:0] dat);
    exp_t e;
    logic stall;
    int   n;
    n = 0;
    drive(is_w, 1'b1, 1'b1, we, adr, dat);
    #1;
    stall = is_w ? mw.stall_i : mr.stall_i;
    while (stall && n < 20) begin
      tick();
      stall = is_w ? mw.stall_i : mr.stall_i;
      n++;
    end
    if (stall) begin
      chk(is_w ? "w_grant_timeout" : "r_grant_timeout", stall, 1'b0);
      drive(is_w, 1'b1, 1'b0, 1'b0, adr, dat);
      return;
    end
    e.chk  = !(is_w && we) && model_vld[adr];
    e.data = model[adr];
    if (is_w && we) begin
      model[adr]     = dat;
      model_vld[adr] = 1'b1;
    end
    if (is_w) q_w.push_back(e);
    else      q_r.push_back(e);
    tick();
    drive(is_w, 1'b1, 1'b0, 1'b0, adr, dat);
  endtask

  task automatic release_port(input bit is_w);
    tick();
    drive(is_w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mw.ack_i) begin
        chk("w_ack_granted", dut.grant_w, 1'b1);
        chk("w_ack_expected", q_w.size() != 0, 1'b1);
        if (q_w.size() != 0) begin
          mon_e = q_w.pop_front();
          if (mon_e.chk) chk("w_rdata", mw.dat_i, mon_e.data);
        end
      end
      if (mr.ack_i) begin
        chk("r_ack_granted", dut.grant_r, 1'b1);
        chk("r_ack_expected", q_r.size() != 0, 1'b1);
        if (q_r.size() != 0) begin
          mon_e = q_r.pop_front();
          if (mon_e.chk) chk("r_rdata", mr.dat_i, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      model[i]     = 8'h00;
      model_vld[i] = 1'b0;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b0;

    // Reset state
    repeat (10) tick();
    chk("rst_grant_r", dut.grant_r, 1'b0);
    chk("rst_grant_w", dut.grant_w, 1'b0);
    chk("rst_stall_w", mw.stall_i, 1'b0);
    chk("rst_stall_r", mr.stall_i, 1'b0);
    chk("rst_ack_w", mw.ack_i, 1'b0);
    chk("rst_ack_r", mr.ack_i, 1'b0);
    chk("rst_dat_w", mw.dat_i, 8'h00);
    chk("rst_dat_r", mr.dat_i, 8'h00);
    rst_n = 1'b1;
    tick();

    // R owns, W waits, R releases and W writes 0xAA @ 0x20
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    #1;
    chk("s2_r_stall_pre", mr.stall_i, 1'b1);
    tick();
    chk("s2_grant_r", dut.grant_r, 1'b1);
    issue(1'b0, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'hAA);
    tick();
    chk("s2_w_stall", mw.stall_i, 1'b1);
    chk("s2_grant_w_pre", dut.grant_w, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("s2_grant_w", dut.grant_w, 1'b1);
    chk("s2_grant_r_off", dut.grant_r, 1'b0);
    issue(1'b1, 1'b1, 8'h20, 8'hAA);
    release_port(1'b1);

    // W writes 0xBB @ 0x30, R waits for 0x40
    tick();
    chk("s3_idle_grant_w", dut.grant_w, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    tick();
    chk("s3_grant_w", dut.grant_w, 1'b1);
    issue(1'b1, 1'b1, 8'h30, 8'hBB);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
    #1;
    chk("s3_r_stall", mr.stall_i, 1'b1);
    release_port(1'b1);
    tick();
    chk("s3_grant_r", dut.grant_r, 1'b1);
    issue(1'b0, 1'b0, 8'h40, 8'h00);
    release_port(1'b0);

    // Back-to-back readback
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    issue(1'b0, 1'b0, 8'h20, 8'h00);
    issue(1'b0, 1'b0, 8'h30, 8'h00);
    release_port(1'b0);

    // Simultaneous request from idle resolves to R
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h50, 8'h77);
    tick();
    chk("s5_grant_r", dut.grant_r, 1'b1);
    chk("s5_grant_w", dut.grant_w, 1'b0);
    chk("s5_w_stall", mw.stall_i, 1'b1);
    issue(1'b0, 1'b0, 8'h20, 8'h00);
    chk("s5_w_stall_hold", mw.stall_i, 1'b1);
    release_port(1'b0);
    chk("s5_w_stall_rel", mw.stall_i, 1'b1);
    tick();
    chk("s5_grant_w_after", dut.grant_w, 1'b1);
    issue(1'b1, 1'b1, 8'h50, 8'h77);
    release_port(1'b1);

    // R attempts a write; memory must be untouched
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    issue(1'b0, 1'b1, 8'h20, 8'h55);
    issue(1'b0, 1'b0, 8'h20, 8'h00);
    release_port(1'b0);

    // Asynchronous reset while W owns; contents persist
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("s7_grant_w", dut.grant_w, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s7_rst_grant_w", dut.grant_w, 1'b0);
    chk("s7_rst_grant_r", dut.grant_r, 1'b0);
    chk("s7_rst_w_stall", mw.stall_i, 1'b1);
    chk("s7_rst_ack_w", mw.ack_i, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    issue(1'b0, 1'b0, 8'h30, 8'h00);
    issue(1'b0, 1'b0, 8'h50, 8'h00);
    release_port(1'b0);

    repeat (3) tick();
    chk("w_queue_drained", q_w.size(), 0);
    chk("r_queue_drained", q_r.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
